// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_engine NPU block and the pooling/FC stages after it.
// Holds the FSM state type, output-size arithmetic and the default datapath widths.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int W_W_DEF    = 8;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int out_dim(input int in_sz, input int k, input int s, input int p);
    return (in_sz + 2 * p - k) / s + 1;
  endfunction

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Serial multiply-accumulate: unsigned pixel times signed weight, accumulated into a signed register.
// acc_next exposes the value the register will take so a downstream stage can capture the final sum.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DATA_W-1:0]        pixel,
  input  logic signed [W_W-1:0]    weight,
  output logic signed [ACC_W-1:0]  acc_next
);

  localparam int P_W = DATA_W + W_W + 1;

  logic signed [DATA_W:0]    pix_s;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;

  // A zero MSB lets the unsigned pixel take part in a signed multiply.
  assign pix_s    = {1'b0, pixel};
  assign prod     = P_W'(pix_s) * P_W'(weight);
  assign acc_base = clr ? '0 : acc;
  assign acc_next = acc_base + ACC_W'(prod);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// KxK multi-channel convolution engine with stride/zero padding, one MAC per cycle, streamed output.
// Optional macro CONV_ENGINE_RELU_EN clamps negative results to zero at the output register.
module conv_engine
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 10,
  parameter int STRIDE = 1,
  parameter int PAD    = 0,
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  localparam int OUT_H = out_dim(IN_H, K, STRIDE, PAD),
  localparam int OUT_W = out_dim(IN_W, K, STRIDE, PAD),
  localparam int AW    = cnt_w(IN_CH * IN_H * IN_W),
  localparam int CH_W  = cnt_w(OUT_CH),
  localparam int ROW_W = cnt_w(OUT_H),
  localparam int COL_W = cnt_w(OUT_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     img_rd_en,
  output logic [AW-1:0]            img_rd_addr,
  input  logic [DATA_W-1:0]        img_rd_data,
  input  logic signed [W_W-1:0]    w_conv [K][K][IN_CH][OUT_CH],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic [ROW_W-1:0]         out_row,
  output logic [COL_W-1:0]         out_col,
  output logic                     out_last
);

  localparam int IC_W = cnt_w(IN_CH);
  localparam int KW   = cnt_w(K);

  if (ACC_W < DATA_W + W_W + 1 + $clog2(K * K * IN_CH)) begin : g_acc_chk
    $error("conv_engine: ACC_W=%0d too narrow for a %0dx%0dx%0d dot product", ACC_W, K, K, IN_CH);
  end

  state_t               state;
  logic [CH_W-1:0]      oc;
  logic [ROW_W-1:0]     orow;
  logic [COL_W-1:0]     ocol;
  logic [IC_W-1:0]      ic;
  logic [KW-1:0]        kr;
  logic [KW-1:0]        kc;

  logic                 first_tap;
  logic                 last_tap;
  logic                 last_pix;
  int                   r_i;
  int                   c_i;
  logic                 tap_in;

  logic                 tap_vld_d;
  logic                 tap_clr_d;
  logic                 pad_d;
  logic signed [W_W-1:0] w_d;
  logic [DATA_W-1:0]    mac_pixel;
  logic signed [ACC_W-1:0] acc_next;

  assign first_tap = (ic == '0) && (kr == '0) && (kc == '0);
  assign last_tap  = (ic == IC_W'(IN_CH - 1)) && (kr == KW'(K - 1)) && (kc == KW'(K - 1));
  assign last_pix  = (oc == CH_W'(OUT_CH - 1)) && (orow == ROW_W'(OUT_H - 1)) &&
                     (ocol == COL_W'(OUT_W - 1));

  // NOTE: every variable assigned here gets a value on all paths, so no latch is inferred.
  always_comb begin
    r_i    = int'(orow) * STRIDE + int'(kr) - PAD;
    c_i    = int'(ocol) * STRIDE + int'(kc) - PAD;
    tap_in = (r_i >= 0) && (r_i < IN_H) && (c_i >= 0) && (c_i < IN_W);
  end

  // Padding taps never touch the buffer; their contribution is forced to zero downstream.
  assign img_rd_en   = (state == S_MAC) && tap_in;
  assign img_rd_addr = tap_in ? AW'(int'(ic) * (IN_H * IN_W) + r_i * IN_W + c_i) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      oc    <= '0;
      orow  <= '0;
      ocol  <= '0;
      ic    <= '0;
      kr    <= '0;
      kc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_MAC;
        end
        S_MAC: begin
          if (last_tap) begin
            ic    <= '0;
            kr    <= '0;
            kc    <= '0;
            state <= S_DRAIN;
          end else if (kc == KW'(K - 1)) begin
            kc <= '0;
            if (kr == KW'(K - 1)) begin
              kr <= '0;
              ic <= ic + IC_W'(1);
            end else begin
              kr <= kr + KW'(1);
            end
          end else begin
            kc <= kc + KW'(1);
          end
        end
        S_DRAIN: state <= S_OUT;
        S_OUT: begin
          if (out_ready) begin
            if (last_pix) begin
              oc    <= '0;
              orow  <= '0;
              ocol  <= '0;
              state <= S_DONE;
            end else begin
              state <= S_MAC;
              if (ocol == COL_W'(OUT_W - 1)) begin
                ocol <= '0;
                if (orow == ROW_W'(OUT_H - 1)) begin
                  orow <= '0;
                  oc   <= oc + CH_W'(1);
                end else begin
                  orow <= orow + ROW_W'(1);
                end
              end else begin
                ocol <= ocol + COL_W'(1);
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tap side-information is delayed one cycle to line up with the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_vld_d <= 1'b0;
      tap_clr_d <= 1'b0;
      pad_d     <= 1'b0;
      w_d       <= '0;
    end else begin
      tap_vld_d <= (state == S_MAC);
      tap_clr_d <= (state == S_MAC) && first_tap;
      pad_d     <= !tap_in;
      w_d       <= w_conv[kr][kc][ic][oc];
    end
  end

  assign mac_pixel = pad_d ? '0 : img_rd_data;

  conv_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tap_clr_d),
    .en       (tap_vld_d),
    .pixel    (mac_pixel),
    .weight   (w_d),
    .acc_next (acc_next)
  );

  // The last product lands during DRAIN, so the output register takes the running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (state == S_DRAIN) begin
`ifdef CONV_ENGINE_RELU_EN
      out_data <= acc_next[ACC_W-1] ? '0 : acc_next;
`else
      out_data <= acc_next;
`endif
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_OUT);
  assign out_last  = out_valid && last_pix;
  assign out_chan  = oc;
  assign out_row   = orow;
  assign out_col   = ocol;

endmodule
